// File: rtl/bp_cce_pending_counter_table_if.sv
// ----------------------------------------------------------------------------
// bp_cce_pending_counter_table_if
//
// Purpose:
//   Bundles the operation, read and write-notification signals of the CCE
//   pending counter table so the control path and the table share one port.
//
// Signals (names are from the table's point of view):
//   ready_o      table initialized; ops and reads accepted
//   op_v_i       operation valid
//   op_i         0=inc, 1=dec, 2=clear, 3=reserved
//   op_wg_i      target way group
//   r_v_i        read request
//   r_wg_i       read way group
//   r_v_o        read response valid (one-cycle pulse)
//   r_pending_o  read counter is non-zero
//   r_count_o    read counter value
//   w_v_o        counter write notification (one-cycle pulse)
//   w_wg_o       written way group
//   w_val_o      new counter value
//   err_o        one-cycle pulse on overflow, underflow or reserved op
//
// Modports:
//   slave   the counter table
//   master  the CCE control path / consumer of responses
// ----------------------------------------------------------------------------
interface bp_cce_pending_counter_table_if #(
    parameter int num_way_groups_p = 64,
    parameter int width_p          = 3
);

    localparam int lg_num_way_groups_lp =
        (num_way_groups_p <= 1) ? 1 : $clog2(num_way_groups_p);

    logic                            ready_o;
    logic                            op_v_i;
    logic [1:0]                      op_i;
    logic [lg_num_way_groups_lp-1:0] op_wg_i;
    logic                            r_v_i;
    logic [lg_num_way_groups_lp-1:0] r_wg_i;
    logic                            r_v_o;
    logic                            r_pending_o;
    logic [width_p-1:0]              r_count_o;
    logic                            w_v_o;
    logic [lg_num_way_groups_lp-1:0] w_wg_o;
    logic [width_p-1:0]              w_val_o;
    logic                            err_o;

    modport slave (
        output ready_o,
        input  op_v_i,
        input  op_i,
        input  op_wg_i,
        input  r_v_i,
        input  r_wg_i,
        output r_v_o,
        output r_pending_o,
        output r_count_o,
        output w_v_o,
        output w_wg_o,
        output w_val_o,
        output err_o
    );

    modport master (
        input  ready_o,
        output op_v_i,
        output op_i,
        output op_wg_i,
        output r_v_i,
        output r_wg_i,
        input  r_v_o,
        input  r_pending_o,
        input  r_count_o,
        input  w_v_o,
        input  w_wg_o,
        input  w_val_o,
        input  err_o
    );

endinterface

// File: rtl/bp_cce_pending_counter_table.sv
// ----------------------------------------------------------------------------
// bp_cce_pending_counter_table
//
// Purpose:
//   Per-way-group saturating pending-transaction counters for the CCE.
//   Accepts inc / dec / clear operations, answers registered pending-bit
//   reads with write-before-read bypass, and reports every counter update on
//   a registered write-notification port feeding the pending tracer.
//   After reset a sweep zeroes one entry per cycle before the table is ready.
//
// Ports:
//   clk_i    clock, posedge
//   reset_i  asynchronous, active-low reset
//   tbl      bp_cce_pending_counter_table_if.slave (ops, reads, notifications)
// ----------------------------------------------------------------------------
module bp_cce_pending_counter_table #(
    parameter int num_way_groups_p = 64,
    parameter int width_p          = 3
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    bp_cce_pending_counter_table_if.slave     tbl
);

    localparam int lg_num_way_groups_lp =
        (num_way_groups_p <= 1) ? 1 : $clog2(num_way_groups_p);

    localparam logic [lg_num_way_groups_lp-1:0] last_idx_lp =
        lg_num_way_groups_lp'(num_way_groups_p - 1);
    localparam logic [width_p-1:0] max_cnt_lp = {width_p{1'b1}};
    localparam logic [width_p-1:0] one_lp     = width_p'(1);

    typedef enum logic {
        STATE_INIT  = 1'b0,
        STATE_READY = 1'b1
    } state_e;

    state_e                          state_q, state_d;
    logic [lg_num_way_groups_lp-1:0] sweep_idx_q, sweep_idx_d;
    logic                            ready_q, ready_d;
    logic                            r_v_q, r_v_d;
    logic                            r_pending_q, r_pending_d;
    logic [width_p-1:0]              r_count_q, r_count_d;
    logic                            w_v_q, w_v_d;
    logic [lg_num_way_groups_lp-1:0] w_wg_q, w_wg_d;
    logic [width_p-1:0]              w_val_q, w_val_d;
    logic                            err_q, err_d;

    // Counter storage is deliberately not reset: the INIT sweep clears it.
    logic [width_p-1:0]              cnt_mem [num_way_groups_p];
    logic                            mem_we;
    logic [lg_num_way_groups_lp-1:0] mem_waddr;
    logic [width_p-1:0]              mem_wdata;

    logic [width_p-1:0]              op_cur;
    logic [width_p-1:0]              rd_val;

    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        ready_d     = 1'b0;
        r_v_d       = 1'b0;
        r_pending_d = r_pending_q;
        r_count_d   = r_count_q;
        w_v_d       = 1'b0;
        w_wg_d      = w_wg_q;
        w_val_d     = w_val_q;
        err_d       = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = sweep_idx_q;
        mem_wdata   = '0;
        op_cur      = cnt_mem[tbl.op_wg_i];
        rd_val      = '0;

        unique case (state_q)
            STATE_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = sweep_idx_q;
                mem_wdata = '0;
                if (sweep_idx_q == last_idx_lp) begin
                    state_d     = STATE_READY;
                    ready_d     = 1'b1;
                    sweep_idx_d = '0;
                end else begin
                    sweep_idx_d = sweep_idx_q + 1'b1;
                end
            end

            STATE_READY: begin
                ready_d = 1'b1;
                if (tbl.op_v_i) begin
                    mem_waddr = tbl.op_wg_i;
                    unique case (tbl.op_i)
                        2'd0: begin
                            // Saturate at max rather than wrap; flag it instead.
                            if (op_cur == max_cnt_lp) begin
                                err_d = 1'b1;
                            end else begin
                                mem_we    = 1'b1;
                                mem_wdata = op_cur + one_lp;
                            end
                        end
                        2'd1: begin
                            if (op_cur == '0) begin
                                err_d = 1'b1;
                            end else begin
                                mem_we    = 1'b1;
                                mem_wdata = op_cur - one_lp;
                            end
                        end
                        2'd2: begin
                            // Clear always notifies, even on an already-zero entry.
                            mem_we    = 1'b1;
                            mem_wdata = '0;
                        end
                        default: begin
                            err_d = 1'b1;
                        end
                    endcase
                    if (mem_we) begin
                        w_v_d   = 1'b1;
                        w_wg_d  = tbl.op_wg_i;
                        w_val_d = mem_wdata;
                    end
                end

                if (tbl.r_v_i) begin
                    // Bypass the write accepted on the same edge so the read sees it.
                    if (mem_we && (mem_waddr == tbl.r_wg_i)) begin
                        rd_val = mem_wdata;
                    end else begin
                        rd_val = cnt_mem[tbl.r_wg_i];
                    end
                    r_v_d       = 1'b1;
                    r_count_d   = rd_val;
                    r_pending_d = |rd_val;
                end
            end

            default: begin
                state_d     = STATE_INIT;
                sweep_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= STATE_INIT;
            sweep_idx_q <= '0;
            ready_q     <= 1'b0;
            r_v_q       <= 1'b0;
            r_pending_q <= 1'b0;
            r_count_q   <= '0;
            w_v_q       <= 1'b0;
            w_wg_q      <= '0;
            w_val_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
            ready_q     <= ready_d;
            r_v_q       <= r_v_d;
            r_pending_q <= r_pending_d;
            r_count_q   <= r_count_d;
            w_v_q       <= w_v_d;
            w_wg_q      <= w_wg_d;
            w_val_q     <= w_val_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            cnt_mem[mem_waddr] <= mem_wdata;
        end
    end

    assign tbl.ready_o     = ready_q;
    assign tbl.r_v_o       = r_v_q;
    assign tbl.r_pending_o = r_pending_q;
    assign tbl.r_count_o   = r_count_q;
    assign tbl.w_v_o       = w_v_q;
    assign tbl.w_wg_o      = w_wg_q;
    assign tbl.w_val_o     = w_val_q;
    assign tbl.err_o       = err_q;

endmodule

// File: tb/tb_bp_cce_pending_counter_table.sv
// ----------------------------------------------------------------------------
// tb_bp_cce_pending_counter_table
//
// Purpose:
//   Scoreboard bench for bp_cce_pending_counter_table. A stimulus process
//   drives ops/reads and pushes expected notifications, errors and read
//   responses (tagged with the cycle they must appear in) into queues; a
//   monitor pops and compares whenever the DUT presents an output.
// ----------------------------------------------------------------------------
module tb_bp_cce_pending_counter_table;

    localparam int N    = 64;
    localparam int W    = 3;
    localparam int MAXV = (1 << W) - 1;

    typedef struct {
        int cyc;
        int wg;
        int val;
    } wexp_t;

    typedef struct {
        int cyc;
        int val;
    } rexp_t;

    logic clk;
    logic reset_i;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int init_edges = 0;
    int model_cnt [N];

    wexp_t wq [$];
    int    eq [$];
    rexp_t rq [$];

    bp_cce_pending_counter_table_if #(.num_way_groups_p(N), .width_p(W)) tbl_if ();

    bp_cce_pending_counter_table #(
        .num_way_groups_p(N),
        .width_p         (W)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset_i),
        .tbl    (tbl_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Edges counted since reset release; the table is usable once N have passed.
    always @(posedge clk or negedge reset_i) begin
        if (!reset_i) init_edges <= 0;
        else if (init_edges < N) init_edges <= init_edges + 1;
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic reportMissing(input string name, input int due);
        checks++;
        errors++;
        $display("[TB] FAIL %s actual=absent expected=present_at_cycle_%0d (cycle %0d)", name, due, cyc);
    endtask

    task automatic reportUnexpected(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s actual=1 expected=0 (cycle %0d)", name, cyc);
    endtask

    task automatic clearModel();
        for (int i = 0; i < N; i++) model_cnt[i] = 0;
        wq.delete();
        eq.delete();
        rq.delete();
    endtask

    task automatic applyStimulus(input bit ov, input int o, input int wg,
                                 input bit rv, input int rwg);
        int tag;
        @(negedge clk);
        tbl_if.op_v_i  = ov;
        tbl_if.op_i    = 2'(o);
        tbl_if.op_wg_i = 6'(wg);
        tbl_if.r_v_i   = rv;
        tbl_if.r_wg_i  = 6'(rwg);
        @(posedge clk);
        if (reset_i && init_edges == N) begin
            tag = cyc + 1;
            if (ov) begin
                case (o)
                    0: if (model_cnt[wg] == MAXV) eq.push_back(tag);
                       else begin
                           model_cnt[wg] = model_cnt[wg] + 1;
                           wq.push_back('{tag, wg, model_cnt[wg]});
                       end
                    1: if (model_cnt[wg] == 0) eq.push_back(tag);
                       else begin
                           model_cnt[wg] = model_cnt[wg] - 1;
                           wq.push_back('{tag, wg, model_cnt[wg]});
                       end
                    2: begin
                           model_cnt[wg] = 0;
                           wq.push_back('{tag, wg, 0});
                       end
                    default: eq.push_back(tag);
                endcase
            end
            if (rv) rq.push_back('{tag, model_cnt[rwg]});
        end
        #1;
        tbl_if.op_v_i = 1'b0;
        tbl_if.r_v_i  = 1'b0;
    endtask

    task automatic randomOp(input int wg_max, input int n);
        int r, op;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 9);
            op = (r < 5) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 3;
            applyStimulus($urandom_range(0, 1) != 0, op, $urandom_range(0, wg_max),
                          $urandom_range(0, 2) == 0, $urandom_range(0, wg_max));
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ready_o"},     tbl_if.ready_o,     0);
        checkOutput({tag, "_r_v_o"},       tbl_if.r_v_o,       0);
        checkOutput({tag, "_r_pending_o"}, tbl_if.r_pending_o, 0);
        checkOutput({tag, "_r_count_o"},   tbl_if.r_count_o,   0);
        checkOutput({tag, "_w_v_o"},       tbl_if.w_v_o,       0);
        checkOutput({tag, "_w_wg_o"},      tbl_if.w_wg_o,      0);
        checkOutput({tag, "_w_val_o"},     tbl_if.w_val_o,     0);
        checkOutput({tag, "_err_o"},       tbl_if.err_o,       0);
    endtask

    // Monitor: overdue expectations are reported as missing, presented outputs
    // are matched against the head of their queue including the cycle tag.
    always @(negedge clk) begin
        if (reset_i) begin
            checkOutput("ready_o", tbl_if.ready_o, (init_edges == N) ? 1 : 0);

            while (wq.size() > 0 && wq[0].cyc < cyc) begin
                reportMissing("w_v_o_missing", wq[0].cyc);
                void'(wq.pop_front());
            end
            while (eq.size() > 0 && eq[0] < cyc) begin
                reportMissing("err_o_missing", eq[0]);
                void'(eq.pop_front());
            end
            while (rq.size() > 0 && rq[0].cyc < cyc) begin
                reportMissing("r_v_o_missing", rq[0].cyc);
                void'(rq.pop_front());
            end

            if (tbl_if.w_v_o) begin
                if (wq.size() == 0) reportUnexpected("w_v_o_unexpected");
                else begin
                    wexp_t e;
                    e = wq.pop_front();
                    checkOutput("w_cycle", cyc, e.cyc);
                    checkOutput("w_wg_o", tbl_if.w_wg_o, e.wg);
                    checkOutput("w_val_o", tbl_if.w_val_o, e.val);
                end
            end

            if (tbl_if.err_o) begin
                if (eq.size() == 0) reportUnexpected("err_o_unexpected");
                else checkOutput("err_cycle", cyc, eq.pop_front());
            end

            if (tbl_if.r_v_o) begin
                if (rq.size() == 0) reportUnexpected("r_v_o_unexpected");
                else begin
                    rexp_t e;
                    e = rq.pop_front();
                    checkOutput("r_cycle", cyc, e.cyc);
                    checkOutput("r_count_o", tbl_if.r_count_o, e.val);
                    checkOutput("r_pending_o", tbl_if.r_pending_o, (e.val != 0) ? 1 : 0);
                end
            end
        end
    end

    initial begin
        tbl_if.op_v_i  = 1'b0;
        tbl_if.op_i    = 2'd0;
        tbl_if.op_wg_i = '0;
        tbl_if.r_v_i   = 1'b0;
        tbl_if.r_wg_i  = '0;
        reset_i = 1'b1;
        clearModel();
        #1 reset_i = 1'b0;
        #2 checkAllZero("reset");

        @(negedge clk);
        @(negedge clk);
        reset_i = 1'b1;

        // Ops issued while sweeping must be ignored.
        randomOp(15, N - 1);
        applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] table ready, directed ops");
        applyStimulus(0, 0, 0, 1, 5);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 3, 0, 0);
        applyStimulus(0, 0, 0, 1, 3);

        for (int i = 0; i < 8; i++) applyStimulus(1, 0, 7, 0, 0);
        applyStimulus(0, 0, 0, 1, 7);

        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 2, 0, 0, 0);
        applyStimulus(1, 3, 4, 1, 4);

        applyStimulus(1, 0, 9, 0, 0);
        applyStimulus(1, 0, 9, 0, 0);
        applyStimulus(1, 0, 9, 1, 9);
        applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] random traffic");
        randomOp(7, 400);

        $display("[TB] reset during ready");
        applyStimulus(1, 2, 2, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 2, 0, 0);
        applyStimulus(1, 0, 5, 1, 2);
        @(posedge clk);
        #2 reset_i = 1'b0;
        #1 checkAllZero("midreset");
        clearModel();
        @(negedge clk);
        @(negedge clk);
        reset_i = 1'b1;

        randomOp(15, N);
        applyStimulus(0, 0, 0, 1, 2);
        applyStimulus(1, 0, 2, 1, 2);
        randomOp(15, 100);

        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("w_queue_left", wq.size(), 0);
        checkOutput("err_queue_left", eq.size(), 0);
        checkOutput("r_queue_left", rq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_cce_pending_counter_table.md
# bp_cce_pending_counter_table

Per-way-group pending-transaction counter table for the CCE. It accepts increment, decrement and clear operations from the CCE control path and answers registered pending-bit reads. Every counter update is emitted on a registered write-notification port (w_v_o / w_wg_o / w_val_o), which feeds the nonsynth CCE pending tracer directly downstream. A post-reset sweep FSM zeroes the table.

## Interface
- num_way_groups_p, 64, number of way groups (counters); power of two, ≥2
- width_p, 3, counter width in bits
- lg_num_way_groups_lp, `BSG_SAFE_CLOG2(num_way_groups_p), derived index width (localparam)

- clk_i  in  1  clock, posedge
- reset_i  in  1  reset, asynchronous, active-low
- ready_o  out  1  table initialized; ops and reads accepted
- op_v_i  in  1  operation valid
- op_i  in  2  0=inc, 1=dec, 2=clear, 3=reserved
- op_wg_i  in  lg_num_way_groups_lp  target way group
- r_v_i  in  1  read request
- r_wg_i  in  lg_num_way_groups_lp  read way group
- r_v_o  out  1  read response valid
- r_pending_o  out  1  counter ≠ 0
- r_count_o  out  width_p  counter value
- w_v_o  out  1  counter write notification
- w_wg_o  out  lg_num_way_groups_lp  written way group
- w_val_o  out  width_p  new counter value
- err_o  out  1  one-cycle pulse: overflow, underflow or reserved op

## Operation
- FSM states: INIT, READY.
- reset_i low (async): state←INIT, sweep index←0, all outputs←0 immediately. Counter storage is not reset; INIT clears it.
- INIT: one entry zeroed per cycle, index 0..num_way_groups_p-1.
  - ready_o=0; op_v_i and r_v_i ignored; no w_v_o, no err_o.
  - After the last index, the state moves to READY.
- READY: ready_o=1.
  - An op is accepted at every posedge with op_v_i=1.
  - inc: count+1. At max (2^width_p-1): no change, no w_v_o, err_o pulse.
  - dec: count-1. At 0: no change, no w_v_o, err_o pulse.
  - clear: count←0. Always writes and emits w_v_o, even if already 0.
  - op 3: no change, no w_v_o, err_o pulse.
- Reads: r_v_i accepted in READY only. The response reflects the table after any op accepted on the same edge (write-before-read bypass).
- Reset asserted mid-INIT or mid-READY: all contents are treated as lost and the full sweep restarts on deassertion. An in-flight read response or write notification is dropped.
- Widths: counters are unsigned width_p bits with no wrap-around (saturating with error). The index is compared against num_way_groups_p-1 for sweep termination.

## Timing
- Reset values: ready_o=0, r_v_o=0, r_pending_o=0, r_count_o=0, w_v_o=0, w_wg_o=0, w_val_o=0, err_o=0.
- Init latency: ready_o rises on the num_way_groups_p-th posedge after reset_i deasserts (64 cycles at default).
- Op: sampled at edge N; the counter is updated at edge N.
  - w_v_o/w_wg_o/w_val_o are valid during cycle N+1 (after edge N) for exactly one cycle.
  - err_o follows the same timing.
- Back-to-back ops to the same wg on consecutive edges accumulate correctly; w_val_o shows each intermediate value.
- Read: r_v_i sampled at edge N; r_v_o/r_pending_o/r_count_o valid during cycle N+1.
  - r_v_o is a one-cycle pulse.
  - r_pending_o/r_count_o hold their values until the next read.
- Op and read to the same wg at the same edge: the read returns the post-op value.
- No backpressure on w_v_o or on the read response; the consumer must always accept.

## Test plan
- Reset, then idle → ready_o=0 for 64 cycles, 1 on cycle 64; read of wg 5 → r_v_o=1, r_count_o=0, r_pending_o=0.
- inc wg 3 ×3, then read wg 3 → w_val_o sequence 1,2,3 on w_wg_o=3; read returns count 3, pending 1.
- inc wg 7 ×8 (width_p=3) → 7 w_v_o pulses ending at val 7; 8th inc: no w_v_o, err_o=1 one cycle; count stays 7.
- dec wg 0 at 0 → err_o pulse, no w_v_o; clear wg 0 → w_v_o with w_val_o=0.
- inc wg 9 and read wg 9 at the same edge (count was 2) → r_count_o=3 next cycle; w_val_o=3 in the same cycle.
- Drop reset_i mid-READY with wg 2 at count 4 → outputs 0 immediately; after deassertion, 64-cycle INIT; read wg 2 → 0; ops during INIT produce no w_v_o.
